// File: rtl/shift_engine_pkg.sv
// Shared types for the shift/rotate engine: operation codes and control states.
package shift_engine_pkg;

    typedef enum logic [2:0] {
        OpNop = 3'b000,
        OpBsw = 3'b001,
        OpRal = 3'b010,
        OpRar = 3'b011,
        OpShl = 3'b100,
        OpAsr = 3'b101,
        OpLsr = 3'b110,
        OpRsv = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/shift_engine_step.sv
// Single-step combinational shift/rotate/swap on L:A (and MQ when SHIFT_ENGINE_MQ_EN is defined).
module shift_step
    import shift_engine_pkg::*;
#(
    parameter int unsigned W = 12
) (
    input  op_e            op,
    input  logic [W-1:0]   a,
    input  logic           l,
`ifdef SHIFT_ENGINE_MQ_EN
    input  logic [W-1:0]   mq,
    output logic [W-1:0]   mq_nxt,
`endif
    output logic [W-1:0]   a_nxt,
    output logic           l_nxt
);

    always_comb begin
        a_nxt = a;
        l_nxt = l;
`ifdef SHIFT_ENGINE_MQ_EN
        mq_nxt = mq;
`endif
        case (op)
            OpBsw: a_nxt = {a[W/2-1:0], a[W-1:W/2]};
            OpRal: {l_nxt, a_nxt} = {a, l};
            OpRar: {a_nxt, l_nxt} = {l, a};
`ifdef SHIFT_ENGINE_MQ_EN
            // Double-length L:A:MQ shifts
            OpShl: {l_nxt, a_nxt, mq_nxt} = {a, mq, 1'b0};
            OpAsr: {a_nxt, mq_nxt, l_nxt} = {a[W-1], a, mq};
            OpLsr: {a_nxt, mq_nxt, l_nxt} = {1'b0, a, mq};
`else
            OpShl: {l_nxt, a_nxt} = {a, 1'b0};
            OpAsr: {a_nxt, l_nxt} = {a[W-1], a};
            OpLsr: {a_nxt, l_nxt} = {1'b0, a};
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// Multi-cycle shift/rotate engine with start/busy/done handshake.
// Optional SHIFT_ENGINE_MQ_EN extends SHL/ASR/LSR to the double-length L:A:MQ.
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter int unsigned W  = 12,
    parameter int unsigned CW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [CW-1:0] cnt,
    input  logic [W-1:0]  ai,
    input  logic          li,
    input  logic          oe,
`ifdef SHIFT_ENGINE_MQ_EN
    input  logic [W-1:0]  mqi,
    output logic [W-1:0]  mqo,
`endif
    output logic [W-1:0]  ao,
    output logic          lo,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    op_e           op_q, op_d, op_in, step_op;
    logic [W-1:0]  a_q, a_d, step_a_in, step_a;
    logic          l_q, l_d, step_l_in, step_l;
    logic [CW-1:0] rem_q, rem_d;
    logic          accept, running;

    assign op_in   = op_e'(op);
    assign running = (state_q == StRun);
    assign accept  = start && !running;

    // Outside RUN the step unit serves the BSW load path on the incoming operand.
    assign step_op   = running ? op_q : OpBsw;
    assign step_a_in = running ? a_q  : ai;
    assign step_l_in = running ? l_q  : li;

`ifdef SHIFT_ENGINE_MQ_EN
    logic [W-1:0] mq_q, mq_d, step_mq;

    shift_step #(.W(W)) u_step (
        .op     (step_op),
        .a      (step_a_in),
        .l      (step_l_in),
        .mq     (mq_q),
        .mq_nxt (step_mq),
        .a_nxt  (step_a),
        .l_nxt  (step_l)
    );

    assign mqo = mq_q;
`else
    shift_step #(.W(W)) u_step (
        .op    (step_op),
        .a     (step_a_in),
        .l     (step_l_in),
        .a_nxt (step_a),
        .l_nxt (step_l)
    );
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        l_d     = l_q;
        rem_d   = rem_q;
`ifdef SHIFT_ENGINE_MQ_EN
        mq_d    = mq_q;
`endif
        case (state_q)
            StRun: begin
                a_d   = step_a;
                l_d   = step_l;
`ifdef SHIFT_ENGINE_MQ_EN
                mq_d  = step_mq;
`endif
                rem_d = rem_q - CW'(1);
                if (rem_q == CW'(1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: begin
            end
        endcase

        if (accept) begin
            op_d  = op_in;
            a_d   = ai;
            l_d   = li;
            rem_d = cnt;
`ifdef SHIFT_ENGINE_MQ_EN
            mq_d  = mqi;
`endif
            case (op_in)
                OpBsw: begin
                    a_d     = step_a;
                    state_d = StDone;
                end
                OpRal, OpRar, OpShl, OpAsr, OpLsr:
                    state_d = (cnt == '0) ? StDone : StRun;
                default: state_d = StDone;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            a_q     <= '0;
            l_q     <= 1'b0;
            rem_q   <= '0;
`ifdef SHIFT_ENGINE_MQ_EN
            mq_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            l_q     <= l_d;
            rem_q   <= rem_d;
`ifdef SHIFT_ENGINE_MQ_EN
            mq_q    <= mq_d;
`endif
        end
    end

    assign ao   = oe ? a_q : '0;
    assign lo   = l_q;
    assign busy = running;
    assign done = (state_q == StDone);

endmodule
